// File: rtl/him_writer_pkg.sv
// Shared constants for the hit-to-HIM writer: HCM/HIM geometry, the hit
// word width, pending-FIFO depth and the HIM address packing helper.
package him_writer_pkg;

    // HCM / HIM geometry shared with the hit count memory.
    localparam int ROWINDEXBITS_HCM = 10;
    localparam int ROWINDEXBITS_HIM = 8;
    localparam int MAXHITNBITS      = 3;

    // Default hit word width and pending-FIFO depth (power of two).
    localparam int HITDATABITS_DFLT  = 32;
    localparam int HITFIFODEPTH_DFLT = 8;
    localparam int HITFIFOPTRBITS    = $clog2(HITFIFODEPTH_DFLT);

    // Width of the HIM BRAM address: {HIM row, slot}.
    localparam int HIMADDRBITS = ROWINDEXBITS_HIM + MAXHITNBITS;

    // Outcome of an HCM write result as seen by the pairing logic.
    typedef enum logic [2:0] {
        POP_NONE,      // no write result this cycle
        POP_EMPTY,     // result arrived with nothing pending
        POP_ROWERR,    // pending head belongs to a different HCM row
        POP_NEW,       // first hit of this SSID: allocate a new HIM row
        POP_EXIST,     // further hit of a known SSID: use HCM address/slot
        POP_ROWFULL    // row already holds the maximum number of hits
    } pop_kind_e;

    // Pack a HIM row and slot into a BRAM address.
    function automatic logic [HIMADDRBITS-1:0] him_addr_pack(
        input logic [ROWINDEXBITS_HIM-1:0] row,
        input logic [MAXHITNBITS-1:0]      slot
    );
        return {row, slot};
    endfunction

endpackage

// File: rtl/him_writer_if.sv
// Signal bundle between the hit source / HCM result path and the HIM writer.
// The slave side is the writer; the master side drives hits and HCM results.
// Handshake: hit_valid and hcm_valid are single-cycle strobes with no
// back-pressure; each high cycle is one transfer, sampled on the rising clock
// edge. him_write, overflow and dropped are single-cycle result pulses.
interface him_writer_if
    import him_writer_pkg::*;
#(
    parameter int HITDATABITS = HITDATABITS_DFLT
);
    // Hit side (same cycle as the HCM writeRow request)
    logic                        hit_valid;
    logic [ROWINDEXBITS_HCM-1:0] hit_row;
    logic                        hit_is_new;
    logic [HITDATABITS-1:0]      hit_data;

    // HCM result side
    logic                        hcm_valid;
    logic                        hcm_is_write;
    logic [ROWINDEXBITS_HCM-1:0] hcm_row;
    logic [MAXHITNBITS-1:0]      hcm_n_hits;
    logic [ROWINDEXBITS_HIM-1:0] hcm_address;

    // HIM write port and status
    logic                        him_write;
    logic [HIMADDRBITS-1:0]      him_addr;
    logic [HITDATABITS-1:0]      him_data;
    logic                        overflow;
    logic                        dropped;
    logic                        mismatch;
    logic                        fifo_full;
    logic                        busy;

    modport slave (
        input  hit_valid, hit_row, hit_is_new, hit_data,
        input  hcm_valid, hcm_is_write, hcm_row, hcm_n_hits, hcm_address,
        output him_write, him_addr, him_data,
        output overflow, dropped, mismatch, fifo_full, busy
    );

    modport master (
        output hit_valid, hit_row, hit_is_new, hit_data,
        output hcm_valid, hcm_is_write, hcm_row, hcm_n_hits, hcm_address,
        input  him_write, him_addr, him_data,
        input  overflow, dropped, mismatch, fifo_full, busy
    );

endinterface

// File: rtl/hit_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending hits until the
// matching HCM result arrives. A push while full is accepted only when a pop
// happens in the same cycle. Full/empty flags are registered and reflect the
// occupancy after this cycle's push/pop.
module hit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW:0]    count;
    logic [PTRW:0]    count_next;
    logic             do_push;
    logic             do_pop;
    logic             full_q;
    logic             empty_q;

    // Accept/consume decisions and next occupancy.
    always_comb begin
        do_pop     = pop && !empty_q;
        do_push    = push && (!full_q || do_pop);
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (PTRW+1)'(1);
            2'b01:   count_next = count - (PTRW+1)'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents need no reset, pointers and flags guard them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            count   <= count_next;
            full_q  <= (count_next == (PTRW+1)'(DEPTH));
            empty_q <= (count_next == '0);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/him_writer.sv
// Pairs each incoming hit with the HCM result for the same request and turns
// the pair into a HIM BRAM write. New SSIDs get a freshly allocated HIM row
// (slot 0); known SSIDs go to the HCM-supplied row at the pre-increment hit
// count. Saturated rows, pairing errors and FIFO overruns are flagged.
module him_writer
    import him_writer_pkg::*;
#(
    parameter int HITDATABITS  = HITDATABITS_DFLT,
    parameter int HITFIFODEPTH = HITFIFODEPTH_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    him_writer_if.slave       bus
);

    localparam int ENTRYW = ROWINDEXBITS_HCM + 1 + HITDATABITS;

    logic [ENTRYW-1:0]           push_entry;
    logic [ENTRYW-1:0]           head_entry;
    logic [ROWINDEXBITS_HCM-1:0] head_row;
    logic                        head_new;
    logic [HITDATABITS-1:0]      head_data;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop_req;
    pop_kind_e                   pop_kind;

    logic [ROWINDEXBITS_HIM-1:0] next_him_address;
    logic                        him_write_q;
    logic [HIMADDRBITS-1:0]      him_addr_q;
    logic [HITDATABITS-1:0]      him_data_q;
    logic                        overflow_q;
    logic                        dropped_q;
    logic                        mismatch_q;

    assign push_entry = {bus.hit_row, bus.hit_is_new, bus.hit_data};
    assign {head_row, head_new, head_data} = head_entry;

    // Only results of write requests consume a pending hit.
    assign pop_req = bus.hcm_valid && bus.hcm_is_write;

    hit_fifo #(
        .WIDTH (ENTRYW),
        .DEPTH (HITFIFODEPTH)
    ) u_hit_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.hit_valid),
        .wdata (push_entry),
        .pop   (pop_req),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Classify the HCM result against the pending FIFO head.
    always_comb begin
        pop_kind = POP_NONE;
        if (pop_req) begin
            if (fifo_empty) begin
                pop_kind = POP_EMPTY;
            end else if (head_row != bus.hcm_row) begin
                pop_kind = POP_ROWERR;
            end else if (head_new) begin
                pop_kind = POP_NEW;
            end else if (bus.hcm_n_hits == '1) begin
                pop_kind = POP_ROWFULL;
            end else begin
                pop_kind = POP_EXIST;
            end
        end
    end

    // HIM write port, status pulses, sticky mismatch and row allocator.
    always_ff @(posedge clk) begin
        if (!reset) begin
            next_him_address <= '0;
            him_write_q      <= 1'b0;
            him_addr_q       <= '0;
            him_data_q       <= '0;
            overflow_q       <= 1'b0;
            dropped_q        <= 1'b0;
            mismatch_q       <= 1'b0;
        end else begin
            him_write_q <= 1'b0;
            overflow_q  <= (pop_kind == POP_ROWFULL);
            // A lone push into a full FIFO is lost; a same-cycle pop frees room.
            dropped_q   <= bus.hit_valid && fifo_full && !pop_req;
            case (pop_kind)
                POP_EMPTY, POP_ROWERR: begin
                    mismatch_q <= 1'b1;
                end
                POP_NEW: begin
                    him_write_q      <= 1'b1;
                    him_addr_q       <= him_addr_pack(next_him_address, '0);
                    him_data_q       <= head_data;
                    // Wraps modulo the HIM row count, like the HCM allocator.
                    next_him_address <= next_him_address + ROWINDEXBITS_HIM'(1);
                end
                POP_EXIST: begin
                    him_write_q <= 1'b1;
                    him_addr_q  <= him_addr_pack(bus.hcm_address, bus.hcm_n_hits);
                    him_data_q  <= head_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.him_write = him_write_q;
    assign bus.him_addr  = him_addr_q;
    assign bus.him_data  = him_data_q;
    assign bus.overflow  = overflow_q;
    assign bus.dropped   = dropped_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.fifo_full = fifo_full;
    assign bus.busy      = !fifo_empty;

endmodule

// File: doc/him_writer.md
HIM_WRITER -- requirements
Module: him_writer

Interface
REQ-001 Parameter HITDATABITS, 32: width of one stored hit word.
REQ-002 Parameter HITFIFODEPTH, 8: pending-hit FIFO entries, power of two.
REQ-003 Parameters ROWINDEXBITS_HCM, ROWINDEXBITS_HIM, MAXHITNBITS: shared values, not redeclared locally.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 hitValid  in  1  hit presented, same cycle as the HCM writeRow.
REQ-007 hitRow  in  ROWINDEXBITS_HCM  HCM row of the hit.
REQ-008 hitIsNew  in  1  SSID first seen this event (mirrors HCM SSIDIsNew).
REQ-009 hitData  in  HITDATABITS  hit word to store.
REQ-010 hcmValid  in  1  HCM result strobe (HCM newOutput).
REQ-011 hcmIsWrite  in  1  result belongs to a write request; 0 = plain read, ignored.
REQ-012 hcmRow  in  ROWINDEXBITS_HCM  HCM rowPassed.
REQ-013 hcmNHits  in  MAXHITNBITS  pre-increment hit count of the row.
REQ-014 hcmAddress  in  ROWINDEXBITS_HIM  HIM row from the HCM word.
REQ-015 himWrite  out  1  HIM BRAM write enable, one-cycle pulse.
REQ-016 himAddr  out  ROWINDEXBITS_HIM+MAXHITNBITS  {HIM row, slot}.
REQ-017 himData  out  HITDATABITS  hit word to write.
REQ-018 overflow  out  1  pulse: hit discarded, row full.
REQ-019 dropped  out  1  pulse: hit discarded, FIFO full.
REQ-020 mismatch  out  1  sticky: pairing error detected.
REQ-021 fifoFull  out  1  FIFO holds HITFIFODEPTH entries.
REQ-022 busy  out  1  FIFO non-empty.

Function
REQ-023 hitValid pushes {hitRow, hitIsNew, hitData} into the pending FIFO.
REQ-024 hcmValid with hcmIsWrite=1 pops the FIFO head; hcmIsWrite=0 changes nothing.
REQ-025 Push and pop in the same cycle are both honoured, including when full; count unchanged.
REQ-026 Push when full without a same-cycle pop: entry discarded, dropped pulses next cycle.
REQ-027 Pop when empty: no write, mismatch set.
REQ-028 Popped head row != hcmRow: no write, entry consumed, mismatch set.
REQ-029 Head isNew=1: HIM row = internal nextHIMAddress, slot 0, nextHIMAddress increments.
REQ-030 Head isNew=0: HIM row = hcmAddress, slot = hcmNHits.
REQ-031 Slot = 2**MAXHITNBITS-1 (saturated): no write, overflow pulses.
REQ-032 nextHIMAddress wraps modulo 2**ROWINDEXBITS_HIM, matching the HCM allocator.
REQ-033 Latency: himWrite/himAddr/himData registered, asserted the cycle after the popping hcmValid.
REQ-034 himAddr/himData hold their last values when himWrite=0.
REQ-035 fifoFull and busy are registered; they reflect occupancy after the current cycle's push/pop.

Reset
REQ-036 reset=0 at a clock edge empties the FIFO and clears nextHIMAddress to 0.
REQ-037 Reset clears himWrite, overflow, dropped, mismatch, fifoFull and busy to 0, and himAddr and himData to 0.
REQ-038 Reset mid-operation discards pending entries; hcmValid is ignored while reset=0.

Structure
REQ-039 HITDATABITS, HITFIFODEPTH and the derived FIFO pointer width live in MyParameters.vh beside the HCM constants.
REQ-040 The pending FIFO is a sub-module, hit_fifo: synchronous, first-word-fall-through, with full/empty flags.
REQ-041 Pairing, slot computation and the address allocator stay in him_writer.

Verification
REQ-042 Bench: new hit row 5 data 0xA5, then hcmValid write row 5 -> next cycle himWrite, himAddr {0,0}, himData 0xA5; nextHIMAddress becomes 1.
REQ-043 Bench: existing hit row 9, hcmNHits 2, hcmAddress 0x12 -> himAddr {0x12,2}; hcmNHits 7 (MAXHITNBITS=3) -> overflow pulse, no write.
REQ-044 Bench: 8 pushes fill the FIFO -> fifoFull=1; a 9th lone push -> dropped pulse; push+pop together -> no drop, count stays 8.
REQ-045 Bench: hcmValid write on an empty FIFO, or head row 3 against hcmRow 4 -> no himWrite, mismatch sticky until reset.
REQ-046 Bench: 256 new hits (ROWINDEXBITS_HIM=8) -> HIM rows 0..255 then wrap to 0; hcmIsWrite=0 results interleaved produce no writes.
REQ-047 Bench: reset asserted with 3 pending entries -> busy=0 next cycle; a subsequent new hit is written to HIM row 0.
